// File: rtl/upe_abs_sched.sv
// Round-robin scheduler that shares one absolute-value unit among NREQ requesters.
// Define UPE_ABS_SCHED_SATURATE_EN to clamp |most-negative| to the largest positive value instead of wrapping.
module upe_abs_sched #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_sign,
  output logic [$clog2(NREQ)-1:0]   out_id,
  output logic                      out_ovf,
  output logic [1:0]                dbg_state
);
  localparam int IDW = $clog2(NREQ);

  // Handshake: req_ready[i] is a one-cycle accept pulse, combinational in IDLE;
  // the operand is taken on that same edge. out_valid holds with stable payload
  // until a rising edge samples out_ready high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_rr_ptr;
  logic [WIDTH-1:0] r_opd;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sign;
  logic [IDW-1:0]   r_out_id;
  logic             r_out_ovf;

  logic             w_found;
  logic [IDW-1:0]   w_gnt_idx;
  logic [IDW-1:0]   w_cand;
  logic             w_grant;
  logic [WIDTH-1:0] w_opd_sel;
  logic             w_sign;
  logic             w_ovf;
  logic [WIDTH-1:0] w_neg;
  logic [WIDTH-1:0] w_abs;
  logic [WIDTH-1:0] w_res;

  // First valid requester at or after the pointer; power-of-two NREQ wraps by truncation.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = r_rr_ptr + IDW'(k);
      if (!w_found && req_valid[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    w_grant   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_n && w_found) begin
          w_grant              = 1'b1;
          req_ready[w_gnt_idx] = 1'b1;
          w_next               = S_CALC;
        end
      end
      S_CALC:  w_next = S_HOLD;
      S_HOLD:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_opd_sel = req_data[w_gnt_idx*WIDTH +: WIDTH];
  assign w_sign    = r_opd[WIDTH-1];
  assign w_ovf     = w_sign && (r_opd[WIDTH-2:0] == '0);
  assign w_neg     = -r_opd;
  assign w_abs     = w_sign ? w_neg : r_opd;
`ifdef UPE_ABS_SCHED_SATURATE_EN
  assign w_res     = w_ovf ? {1'b0, {(WIDTH-1){1'b1}}} : w_abs;
`else
  assign w_res     = w_abs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_opd      <= '0;
      r_id       <= '0;
      r_out_data <= '0;
      r_out_sign <= 1'b0;
      r_out_id   <= '0;
      r_out_ovf  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_opd    <= w_opd_sel;
        r_id     <= w_gnt_idx;
        r_rr_ptr <= w_gnt_idx + IDW'(1);
      end
      if (r_state == S_CALC) begin
        r_out_data <= w_res;
        r_out_sign <= w_sign;
        r_out_id   <= r_id;
        r_out_ovf  <= w_ovf;
      end
    end
  end

  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_out_data;
  assign out_sign  = r_out_sign;
  assign out_id    = r_out_id;
  assign out_ovf   = r_out_ovf;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_upe_abs_sched.sv
// Bench for upe_abs_sched: a cycle-level reference model predicts grants and results,
// and a separate monitor pops expected results whenever the DUT hands one off.
module tb_upe_abs_sched;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int EW  = IDW + 2 + W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_sign;
  logic [IDW-1:0] out_id;
  logic           out_ovf;
  logic [1:0]     dbg_state;

  logic [EW-1:0]  exp_q[$];
  int             checks = 0;
  int             errors = 0;

  bit             m_busy = 1'b0;
  int             m_age  = 0;
  int             m_rr   = 0;

  bit             h_valid = 1'b0;
  logic [EW-1:0]  h_pay;

  upe_abs_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sign  (out_sign),
    .out_id    (out_id),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected result from plain signed arithmetic.
  function automatic logic [EW-1:0] expect_of(input logic [W-1:0] opd, input int id);
    longint         v;
    longint         mag;
    logic           neg;
    logic           ovf;
    logic [W-1:0]   d;
    logic [IDW-1:0] idv;
    v   = longint'($signed(opd));
    neg = (v < 0);
    mag = neg ? -v : v;
    ovf = (mag == (longint'(1) << (W - 1)));
`ifdef UPE_ABS_SCHED_SATURATE_EN
    if (ovf) mag = mag - 1;
`endif
    d   = mag[W-1:0];
    idv = id[IDW-1:0];
    return {idv, neg, ovf, d};
  endfunction

  // ---------------- reference model ----------------
  always @(negedge clk) begin
    logic [N-1:0] er;
    int           win;
    er  = '0;
    win = -1;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_rr   = 0;
      exp_q.delete();
      check("rst_req_ready", req_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_payload", {out_id, out_sign, out_ovf, out_data}, 0);
    end else if (m_busy) begin
      m_age++;
      check("out_valid_timing", out_valid, (m_age >= 2));
      check("req_ready_busy", req_ready, 0);
      if (m_age >= 2 && out_ready) m_busy = 1'b0;
    end else begin
      check("out_valid_idle", out_valid, 0);
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
      if (win >= 0) begin
        er[win] = 1'b1;
        exp_q.push_back(expect_of(req_data[win*W +: W], win));
        m_busy = 1'b1;
        m_age  = 0;
        m_rr   = (win + 1) % N;
      end
      check("req_ready_grant", req_ready, er);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      h_valid = 1'b0;
    end else if (out_valid) begin
      if (h_valid) check("hold_stable", {out_id, out_sign, out_ovf, out_data}, h_pay);
      if (out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got result %0h, required none", {out_id, out_sign, out_ovf, out_data});
        end else begin
          e = exp_q.pop_front();
          checks--;
          check("result", {out_id, out_sign, out_ovf, out_data}, e);
        end
        h_valid = 1'b0;
      end else begin
        h_valid = 1'b1;
        h_pay   = {out_id, out_sign, out_ovf, out_data};
      end
    end else begin
      h_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic issue(input logic [N-1:0] v, input int idx, input logic [W-1:0] d);
    req_valid = v;
    req_data[idx*W +: W] = d;
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
  endtask

  function automatic logic [W-1:0] rand_opd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return '1;
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // first grant after reset, negative operand
    issue(4'b0001, 0, 32'hFFFF_FFFB);
    // bring pointer back to 0, then all requesters held
    issue(4'b1000, 3, 32'h0000_0010);
    req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < N; i++) req_data[i*W +: W] = rand_opd();
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_idle();

    // backpressure: result held for many cycles while others request
    out_ready = 1'b0;
    req_valid = 4'b0010;
    req_data[1*W +: W] = 32'h8000_0123;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    repeat (12) @(posedge clk);
    #1 out_ready = 1'b1;
    req_valid = '0;
    wait_idle();

    // boundary operands
    issue(4'b0001, 0, 32'h8000_0000);
    issue(4'b0010, 1, 32'h0000_0000);
    issue(4'b1000, 3, 32'h7FFF_FFFF);
    // pointer at 3 after granting 2, then 0101 -> 0 then 2
    issue(4'b0100, 2, 32'hFFFF_FFFF);
    req_data[0 +: W] = 32'h0000_0011;
    issue(4'b0101, 2, 32'hFFFF_FF00);
    issue(4'b0101, 2, 32'hFFFF_FF00);

    // reset while the operand is being computed
    req_valid = 4'b0001;
    req_data[0 +: W] = 32'h0000_0007;
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = 4'b0110;
    #1;
    check("async_rst_req_ready", req_ready, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_payload", {out_id, out_sign, out_ovf, out_data}, 0);
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req_data[1*W +: W] = 32'hFFFF_FFF9;
    issue(4'b1010, 1, 32'hFFFF_FFF9);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) req_data[i*W +: W] = rand_opd();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = '0;
    out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/upe_abs_sched.md
UPE_ABS_SCHED -- requirements
Module: upe_abs_sched

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (two's complement).
REQ-002 Parameter: NREQ, 4, number of requesters (fixed power of two, 2..8).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NREQ  per-requester operand valid.
REQ-007 req_data  input  NREQ*WIDTH  operands; requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  one-hot accept pulse to the granted requester.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_data  output  WIDTH  |operand|.
REQ-012 out_sign  output  1  popped sign (MSB of accepted operand).
REQ-013 out_id  output  log2(NREQ)  index of requester that owns the result.
REQ-014 out_ovf  output  1  operand was the most-negative value (-2^(WIDTH-1)).

Function
REQ-015 FSM SHALL have states IDLE, CALC, HOLD; one shared absolute-value datapath (negate-and-select on sign).
REQ-016 IDLE: if any req_valid set, grant the first set bit at or after rr_ptr (wrapping modulo NREQ), assert req_ready for that bit only, combinationally, same cycle; latch operand and index; go to CALC.
REQ-017 IDLE with no req_valid: req_ready = 0, stay IDLE.
REQ-018 On grant, rr_ptr SHALL become (granted index + 1) mod NREQ; NREQ-1 wraps to 0.
REQ-019 CALC: register out_data, out_sign, out_ovf from latched operand; go to HOLD next cycle; req_ready = 0.
REQ-020 HOLD: out_valid = 1; out_data/out_sign/out_id/out_ovf SHALL stay stable until out_ready sampled high.
REQ-021 HOLD with out_ready = 1: result consumed, out_valid deasserts next cycle, go to IDLE.
REQ-022 Latency: grant edge to out_valid high = 2 cycles; minimum issue interval = 3 cycles.
REQ-023 req_ready SHALL be 0 in CALC and HOLD regardless of req_valid.
REQ-024 Operand zero: out_data = 0, out_sign = 0, out_ovf = 0.
REQ-025 Without the Configuration feature, operand -2^(WIDTH-1) SHALL give out_data = 0x80000000 (wrap), out_sign = 1, out_ovf = 1.
REQ-026 A requester dropping req_valid before grant is not granted; no state retained for it.
REQ-027 out_valid SHALL never be high in IDLE or CALC.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, rr_ptr = 0, out_valid = 0, out_data = 0, out_sign = 0, out_id = 0, out_ovf = 0, req_ready = 0.
REQ-029 Reset during CALC or HOLD SHALL discard the in-flight result; no out_valid after release until a new grant.
REQ-030 First grant after reset release SHALL use rr_ptr = 0.

Configuration
REQ-031 Macro UPE_ABS_SCHED_SATURATE_EN defined: operand -2^(WIDTH-1) SHALL give out_data = 2^(WIDTH-1)-1 (0x7FFFFFFF), out_sign = 1, out_ovf = 1.
REQ-032 Macro undefined: wrap behaviour per REQ-025; out_ovf still reported; all other results identical.

Verification
REQ-033 Reset release, req_valid = 0001, req_data[0] = 0xFFFFFFFB -> req_ready = 0001 that cycle; 2 cycles later out_valid = 1, out_data = 5, out_sign = 1, out_id = 0, out_ovf = 0.
REQ-034 req_valid = 1111 held, out_ready = 1 always -> out_id sequence 0,1,2,3,0 with new result every 3 cycles.
REQ-035 Result in HOLD, out_ready = 0 for 10 cycles -> out_valid and out_data held constant, req_ready = 0 throughout; out_ready = 1 -> out_valid low next cycle.
REQ-036 Operand 0x80000000 -> out_ovf = 1; out_data = 0x80000000 without macro, 0x7FFFFFFF with UPE_ABS_SCHED_SATURATE_EN.
REQ-037 rst_n asserted in CALC with operand 0x00000007 -> all outputs 0 immediately; after release no out_valid until new req_valid; first grant to lowest set index.
REQ-038 rr_ptr = 3 after granting 2, req_valid = 0101 -> grant index 0, then index 2.
